// File: rtl/fp_sqrt_iter.sv
// fp_sqrt_iter: multi-cycle IEEE-754 square root, restoring digit recurrence, one root bit per cycle.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/A operand handshake;
//        out_valid/out_ready/result/invalid/inexact result handshake.
// Define FSQRT_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the root is truncated.
module fp_sqrt_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] A,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 invalid,
    output logic                 inexact
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int R  = MAN_W + 2;
    localparam int RW = R + 3;
    localparam int CW = $clog2(R);
    localparam logic [EXP_W-1:0] EMAX   = '1;
    localparam logic [EXP_W-1:0] BIAS_H = EMAX >> 2;
    localparam logic [W-1:0]     QNAN   = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;
    state_t           state, next_state;
    logic             a_sign;
    logic [EXP_W-1:0] a_exp;
    logic [MAN_W-1:0] a_frac;
    logic             is_nan, special, spec_inv, accept;
    logic [W-1:0]     spec_res;
    logic [2*R-1:0]   rad;
    logic [RW-1:0]    rem, rem_sh, trial, diff;
    logic [R-1:0]     root;
    logic [EXP_W-1:0] exp_r;
    logic [CW-1:0]    cnt;
    logic             ge, guard, sticky, inc;
    logic [MAN_W:0]   fsum;

    assign {a_sign, a_exp, a_frac} = A;
    assign accept = in_valid & in_ready;

    // Special operands resolve in one step; priority NaN, zero/subnormal, negative, +Inf.
    always_comb begin
        is_nan   = (a_exp == EMAX) && (a_frac != '0);
        special  = (a_exp == EMAX) || (a_exp == '0) || a_sign;
        spec_res = is_nan ? QNAN : (a_exp == '0) ? {a_sign, {(W-1){1'b0}}} : a_sign ? QNAN : A;
        spec_inv = is_nan ? ~a_frac[MAN_W-1] : (a_exp != '0) && a_sign;
    end

    // One restoring step: bring down two radicand bits, try subtracting 4q+1.
    assign rem_sh = {rem[RW-3:0], rad[2*R-1 -: 2]};
    assign trial  = {1'b0, root, 2'b01};
    assign diff   = rem_sh - trial;
    assign ge     = rem_sh >= trial;
    assign guard  = root[0];
    assign sticky = |rem;
`ifdef FSQRT_ROUND_NEAREST_EN
    assign inc = guard & (sticky | root[1]);
`else
    assign inc = 1'b0;
`endif
    // Rounding on the fraction only; a carry-out means the significand reached 2.0.
    assign fsum = {1'b0, root[R-2:1]} + {{MAN_W{1'b0}}, inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? (special ? DONE : CALC) : IDLE;
            CALC:    next_state = (cnt == '0) ? ROUND : CALC;
            ROUND:   next_state = DONE;
            DONE:    next_state = out_ready ? IDLE : DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (state == IDLE);
        out_valid = (state == DONE);
    end

    // Odd unbiased exponent (even biased field, since bias is odd) doubles the radicand.
    // Result exponent (E+bias)/2 is formed without a wide adder: E>>1 + bias>>1 + E[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad   <= '0;
            rem   <= '0;
            root  <= '0;
            exp_r <= '0;
            cnt   <= '0;
        end else if (state == IDLE && accept) begin
            rad   <= a_exp[0] ? {2'b01, a_frac, {(MAN_W+2){1'b0}}} : {1'b1, a_frac, {(MAN_W+3){1'b0}}};
            rem   <= '0;
            root  <= '0;
            exp_r <= {1'b0, a_exp[EXP_W-1:1]} + BIAS_H + {{(EXP_W-1){1'b0}}, a_exp[0]};
            cnt   <= CW'(MAN_W + 1);
        end else if (state == CALC) begin
            rad  <= rad << 2;
            rem  <= ge ? diff : rem_sh;
            root <= {root[R-2:0], ge};
            cnt  <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            invalid <= 1'b0;
            inexact <= 1'b0;
        end else if (state == IDLE && accept && special) begin
            result  <= spec_res;
            invalid <= spec_inv;
            inexact <= 1'b0;
        end else if (state == ROUND) begin
            result  <= {1'b0, exp_r + {{(EXP_W-1){1'b0}}, fsum[MAN_W]},
                        fsum[MAN_W] ? {MAN_W{1'b0}} : fsum[MAN_W-1:0]};
            invalid <= 1'b0;
            inexact <= guard | sticky;
        end
    end
endmodule

// File: tb/tb_fp_sqrt_iter.sv
// tb_fp_sqrt_iter: scoreboard bench for fp_sqrt_iter in single, half and double precision.
module tb_fp_sqrt_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          w;
        logic [63:0] a;
        logic [63:0] res;
        logic        inv;
        logic        inx;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, invalid, inexact;
    logic [31:0] a = '0, result;
    logic        h_valid = 1'b0, h_ready, h_ovalid, h_inv, h_inx;
    logic [15:0] h_a = '0, h_res;
    logic        d_valid = 1'b0, d_ready, d_ovalid, d_inv, d_inx;
    logic [63:0] d_a = '0, d_res;

    fp_sqrt_iter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(a),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .invalid(invalid), .inexact(inexact)
    );
    fp_sqrt_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(h_valid), .in_ready(h_ready), .A(h_a),
        .out_valid(h_ovalid), .out_ready(1'b1), .result(h_res),
        .invalid(h_inv), .inexact(h_inx)
    );
    fp_sqrt_iter #(.EXP_W(11), .MAN_W(52)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_valid), .in_ready(d_ready), .A(d_a),
        .out_valid(d_ovalid), .out_ready(1'b1), .result(d_res),
        .invalid(d_inv), .inexact(d_inx)
    );

    logic [2:0]  ov, iv, ix;
    logic [63:0] res [3];
    logic [2:0]  prev_ov = '0;
    assign ov = {d_ovalid, h_ovalid, out_valid};
    assign iv = {d_inv, h_inv, invalid};
    assign ix = {d_inx, h_inx, inexact};
    assign res[0] = {32'b0, result};
    assign res[1] = {48'b0, h_res};
    assign res[2] = d_res;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic rdy(input int w);
        return w == 0 ? in_ready : w == 1 ? h_ready : d_ready;
    endfunction

    // Single-precision reference: double-precision $sqrt cut down to 24 bits.
    task automatic model(input real x, output logic [31:0] r, output logic inx);
        logic [63:0] b;
        logic [23:0] m;
        logic        g, st;
        b  = $realtobits($sqrt(x));
        m  = {1'b0, b[51:29]};
        g  = b[28];
        st = |b[27:0];
`ifdef FSQRT_ROUND_NEAREST_EN
        if (g && (st || m[0])) m = m + 24'd1;
`endif
        r   = {1'b0, 8'(b[62:52] - 11'd896 + {10'd0, m[23]}), m[23] ? 23'd0 : m[22:0]};
        inx = g | st;
    endtask

    task automatic send(input int w, input logic [63:0] v, input logic [63:0] r,
                        input logic inv, input logic inx, input int lat, input bit nowait = 0);
        exp_t e;
        int   n = 0;
        if (!nowait) @(negedge clk);
        if (w == 0) begin in_valid = 1'b1; a = v[31:0]; end
        else if (w == 1) begin h_valid = 1'b1; h_a = v[15:0]; end
        else begin d_valid = 1'b1; d_a = v; end
        while (!rdy(w) && n < 200) begin @(negedge clk); n++; end
        if (!rdy(w)) begin
            checks++; errors++;
            $display("FAIL dut%0d in_ready timeout A=%h got 0 expected 1", w, v);
        end else begin
            e = '{w, v, r, inv, inx, cyc, lat};
            sb.push_back(e);
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0; h_valid = 1'b0; d_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain timeout: %0d results pending, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: checks each result when out_valid rises, against the oldest entry for that unit.
    always @(negedge clk) begin : mon
        int   idx;
        exp_t e;
        for (int w = 0; w < 3; w++) begin
            if (rst_n && ov[w] && !prev_ov[w]) begin
                idx = -1;
                for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].w == w) idx = i;
                if (idx < 0) begin
                    checks++; errors++;
                    $display("FAIL dut%0d spurious out_valid result=%h expected no output", w, res[w]);
                end else begin
                    e = sb[idx];
                    sb.delete(idx);
                    chk($sformatf("dut%0d A=%h result", w, e.a), res[w], e.res);
                    chk($sformatf("dut%0d A=%h invalid", w, e.a), 64'(iv[w]), 64'(e.inv));
                    chk($sformatf("dut%0d A=%h inexact", w, e.a), 64'(ix[w]), 64'(e.inx));
                    chk($sformatf("dut%0d A=%h latency", w, e.a), 64'(cyc - e.acc), 64'(e.lat));
                end
            end
        end
        prev_ov = rst_n ? ov : 3'b000;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] mr;
        logic        mi;
        repeat (3) @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 0);
        chk("reset out_valid", 64'(out_valid), 0);
        chk("reset result", 64'(result), 0);
        chk("reset invalid", 64'(invalid), 0);
        chk("reset inexact", 64'(inexact), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", 64'(in_ready), 1);
        send(0, 32'h41C80000, 32'h40A00000, 0, 0, 27);
        send(0, 32'h40000000, 32'h3FB504F3, 0, 1, 27);
        model(33.0, mr, mi);
        send(0, 32'h42040000, mr, 0, mi, 27);
        model(85.0, mr, mi);
        send(0, 32'h42AA0000, mr, 0, mi, 27);
        model(92.0, mr, mi);
        send(0, 32'h42B80000, mr, 0, mi, 27);
        send(0, 32'hC1C80000, 32'h7FC00000, 1, 0, 1);
        send(0, 32'h7F800000, 32'h7F800000, 0, 0, 1);
        send(0, 32'h80000000, 32'h80000000, 0, 0, 1);
        send(0, 32'h00000001, 32'h00000000, 0, 0, 1);
        send(0, 32'hFF800000, 32'h7FC00000, 1, 0, 1);
        send(0, 32'h7F800001, 32'h7FC00000, 1, 0, 1);
        send(0, 32'h7FC00001, 32'h7FC00000, 0, 0, 1);
        drain();
        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        send(0, 32'h41C80000, 32'h40A00000, 0, 0, 27);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            chk("bp out_valid", 64'(out_valid), 1);
            chk("bp result held", 64'(result), 64'h40A00000);
            chk("bp in_ready", 64'(in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp handshake out_valid", 64'(out_valid), 0);
        chk("bp handshake in_ready", 64'(in_ready), 1);
        send(0, 32'h42B80000, mr, 0, mi, 27, 1);
        drain();
        // Reset in the middle of an iteration.
        model(33.0, mr, mi);
        send(0, 32'h42040000, mr, 0, mi, 27);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid reset out_valid", 64'(out_valid), 0);
        chk("mid reset result", 64'(result), 0);
        chk("mid reset in_ready", 64'(in_ready), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after reset in_ready", 64'(in_ready), 1);
        send(0, 32'h41C80000, 32'h40A00000, 0, 0, 27);
        drain();
        // Other precisions.
        send(1, 64'h4E40, 64'h4500, 0, 0, 14);
        send(2, 64'h4039000000000000, 64'h4014000000000000, 0, 0, 56);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_sqrt_iter.md
Name: fp_sqrt_iter

Overview:
- Parametrised, multi-cycle IEEE-754 floating-point square-root unit; successor to the single-precision Floating_Sqrt in the Floating ALU.
- Generic in exponent/mantissa width (half, single, double) and replaces the free-running EN control with valid/ready handshakes on both sides.
- Root computed by a restoring digit-by-digit datapath, one root bit per cycle.
- Exception flags are produced alongside the result.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa (fraction) width; total word W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand A is valid.
- in_ready  out  1  unit can accept an operand.
- A  in  W  IEEE operand.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  W  IEEE square root.
- invalid  out  1  invalid-operation flag (negative non-zero operand or sNaN).
- inexact  out  1  root not exact, i.e. remainder non-zero or rounding applied.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, in_ready=0 while asserted then 1, out_valid=0, result=0, invalid=0, inexact=0. Any operation in progress is discarded.
- FSM states and transitions:
  - IDLE: in_ready=1. Accept on in_valid&in_ready and latch A. A special operand goes to DONE; otherwise go to CALC.
  - CALC: MAN_W+2 iterations. Iteration counter counts down from MAN_W+1 to 0, then go to ROUND.
  - ROUND: form final mantissa and exponent, then go to DONE.
  - DONE: out_valid=1. result and flags are held stable until out_ready. On out_valid&out_ready go to IDLE; in_ready returns to 1 the next cycle.
- in_ready=0 in CALC, ROUND and DONE. There is no overlap between operations.
- Latency, counted in cycles after the accepting edge:
  - normal operand: out_valid rises at cycle MAN_W+4 (27 for defaults);
  - special operand: out_valid rises at cycle 1.
- Special operands, checked in this order:
  - NaN: result=qNaN (sign 0, exponent all ones, fraction MSB set, rest 0). invalid=1 only if the input is an sNaN.
  - ±0: result=±0 (sign preserved).
  - Subnormal: flushed to zero, result=±0, inexact=0, invalid=0.
  - -Inf or negative normal: result=qNaN, invalid=1.
  - +Inf: result=+Inf.
- Normal operands:
  - Significand S = {1,frac}; unbiased exponent e = E-bias, bias=2^(EXP_W-1)-1.
  - If e is odd, S is shifted left 1 and e is decremented, so the radicand lies in [1,4).
  - Result exponent = e/2+bias; this never overflows or underflows.
  - Radicand is zero-extended to 2*(MAN_W+2) bits and yields MAN_W+2 root bits (1 integer, MAN_W fraction, 1 guard). The root lies in [1,2).
  - Sticky bit = (final remainder != 0).
  - Sign of result = 0.
  - A mantissa carry-out from rounding increments the exponent and zeroes the fraction; RTL must handle this even though it is unreachable for sqrt.
- inexact = guard | sticky.
- A, in_valid and out_ready are ignored outside their respective states.

Optional Feature:
- Macro FSQRT_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even. Increment when guard & (sticky | lsb).
- Undefined: truncation. Guard and sticky are discarded for the result but still drive inexact; the ROUND state remains, so latency is identical.

Test Plan:
- A=0x41C80000 (25.0), out_ready=1 -> result=0x40A00000, inexact=0, invalid=0, out_valid at cycle 27.
- A=0x40000000 (2.0) -> result=0x3FB504F3, inexact=1. Sequence 33.0, 85.0, 92.0 is compared against a $sqrt real model rounded per the macro setting (1 ulp mismatch allowed in neither mode).
- Specials:
  - 0xC1C80000 -> 0x7FC00000, invalid=1.
  - 0x7F800000 -> 0x7F800000.
  - 0x80000000 -> 0x80000000.
  - 0x00000001 -> 0x00000000.
  - Each has out_valid at cycle 1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> result held stable, in_ready=0 throughout. Raise out_ready -> handshake completes, in_ready=1 the next cycle, and a back-to-back operand (0x42B80000) is accepted.
- Reset mid-CALC: drop rst_n at cycle 10 after accepting 0x42040000 -> immediately out_valid=0, result=0. After release, in_ready=1 and a new operand 0x41C80000 gives 0x40A00000.
- Parameter sweep EXP_W=5/MAN_W=10: 0x4E40 (25.0) -> 0x4500 at cycle 14. EXP_W=11/MAN_W=52: 0x4039000000000000 -> 0x4014000000000000 at cycle 56.
